// File: rtl/systolic_vec_feeder.sv
// rtl/systolic_vec_feeder.sv - weight/feature sequencer for one systolic PE vector
//
// Loads ROW weights into the array (ctrl_out = 1 shifts a weight in), then
// streams num_vec_in feature vectors (ctrl_out = 0 computes), tracks which
// array outputs are real results and pulses done_out once the last one is out.
//
// Optional feature: SYS_FEED_SKEW_EN delays row i of feature_out by i cycles
// for diagonal wavefront entry; result latency grows by ROW-1 cycles.
//
// Ports:
//   clk_in1, nrst_in1         clock, synchronous active-low reset
//   start_in, num_vec_in      job start pulse and feature vector count
//   w_valid_in/w_data_in/w_ready_out   weight stream handshake
//   f_valid_in/f_data_in/f_ready_out   feature vector handshake (ROW x WIDTH)
//   ctrl_out, weight_out      array mode (1 = shift weight) and weight value
//   feature_out               per-row array feature inputs
//   res_valid_out             array vector output holds a real result
//   busy_out, done_out        job active, one-cycle completion pulse
module systolic_vec_feeder #(
    parameter int WIDTH   = 8,
    parameter int ROW     = 2,
    parameter int ARR_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic                          clk_in1,
    input  logic                          nrst_in1,
    input  logic                          start_in,
    input  logic [CNT_W-1:0]              num_vec_in,
    input  logic                          w_valid_in,
    input  logic [WIDTH-1:0]              w_data_in,
    output logic                          w_ready_out,
    input  logic                          f_valid_in,
    input  logic [ROW-1:0][WIDTH-1:0]     f_data_in,
    output logic                          f_ready_out,
    output logic                          ctrl_out,
    output logic [WIDTH-1:0]              weight_out,
    output logic [ROW-1:0][WIDTH-1:0]     feature_out,
    output logic                          res_valid_out,
    output logic                          busy_out,
    output logic                          done_out
);

`ifdef SYS_FEED_SKEW_EN
    localparam int D = ARR_LAT + ROW - 1;
`else
    localparam int D = ARR_LAT;
`endif
    localparam int WC_W = (ROW > 1) ? $clog2(ROW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_W, FEED, DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [WC_W-1:0]            w_cnt;
    logic [CNT_W-1:0]           vec_cnt;
    logic                       w_xfer, f_xfer, last_w, last_f, job_go;
    logic                       feat_vld, done_zero_q, pipe_empty;
    logic [D-1:0]               vld_sr;
    logic [ROW-1:0][WIDTH-1:0]  f_q;

    assign w_ready_out   = (state == LOAD_W);
    assign f_ready_out   = (state == FEED);
    assign busy_out      = (state != IDLE);
    assign w_xfer        = w_valid_in & w_ready_out;
    assign f_xfer        = f_valid_in & f_ready_out;
    assign last_w        = (w_cnt == WC_W'(ROW - 1));
    assign last_f        = (vec_cnt == CNT_W'(1));
    assign job_go        = (state == IDLE) && start_in && (num_vec_in != '0);
    // feat_vld marks the feature_out cycle of row 0; since D >= ROW, an empty
    // valid pipeline also means every skewed row has already left.
    assign pipe_empty    = !feat_vld && (vld_sr == '0);
    assign res_valid_out = vld_sr[D-1];
    // A zero-length job completes from IDLE; a real job completes in the
    // last DRAIN cycle, right after its final result.
    assign done_out      = done_zero_q | ((state == DRAIN) && pipe_empty);

    always_ff @(posedge clk_in1) begin
        if (!nrst_in1) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (job_go)            state_nxt = LOAD_W;
            LOAD_W:  if (w_xfer && last_w)  state_nxt = FEED;
            FEED:    if (f_xfer && last_f)  state_nxt = DRAIN;
            DRAIN:   if (pipe_empty)        state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in1) begin
        if (!nrst_in1) begin
            w_cnt       <= '0;
            vec_cnt     <= '0;
            done_zero_q <= 1'b0;
            ctrl_out    <= 1'b0;
            weight_out  <= '0;
            f_q         <= '0;
            feat_vld    <= 1'b0;
            vld_sr      <= '0;
        end else begin
            done_zero_q <= (state == IDLE) && start_in && (num_vec_in == '0);
            if (job_go) begin
                vec_cnt <= num_vec_in;
                w_cnt   <= '0;
            end
            if (w_xfer)
                w_cnt <= last_w ? '0 : w_cnt + 1'b1;
            if (f_xfer && (vec_cnt != '0))
                vec_cnt <= vec_cnt - 1'b1;
            ctrl_out <= w_xfer;
            if (w_xfer)
                weight_out <= w_data_in;
            f_q      <= f_xfer ? f_data_in : '0;
            feat_vld <= f_xfer;
            vld_sr[0] <= feat_vld;
            for (int k = 1; k < D; k++)
                vld_sr[k] <= vld_sr[k-1];
        end
    end

`ifdef SYS_FEED_SKEW_EN
    assign feature_out[0] = f_q[0];
    for (genvar i = 1; i < ROW; i++) begin : g_skew
        logic [i-1:0][WIDTH-1:0] sk;
        always_ff @(posedge clk_in1) begin
            if (!nrst_in1) begin
                sk <= '0;
            end else begin
                sk[0] <= f_q[i];
                for (int k = 1; k < i; k++)
                    sk[k] <= sk[k-1];
            end
        end
        assign feature_out[i] = sk[i-1];
    end
`else
    assign feature_out = f_q;
`endif

endmodule

// File: tb/tb_systolic_vec_feeder.sv
// tb/tb_systolic_vec_feeder.sv - randomized self-checking bench for systolic_vec_feeder
module tb_systolic_vec_feeder;
    localparam int WIDTH   = 8;
    localparam int ROW     = 2;
    localparam int ARR_LAT = 2;
    localparam int CNT_W   = 8;
`ifdef SYS_FEED_SKEW_EN
    localparam int D    = ARR_LAT + ROW - 1;
    localparam int SKEW = 1;
`else
    localparam int D    = ARR_LAT;
    localparam int SKEW = 0;
`endif
    localparam int MAXC = 6000;

    logic                      clk_in1, nrst_in1, start_in;
    logic [CNT_W-1:0]          num_vec_in;
    logic                      w_valid_in, w_ready_out, f_valid_in, f_ready_out;
    logic [WIDTH-1:0]          w_data_in, weight_out;
    logic [ROW-1:0][WIDTH-1:0] f_data_in, feature_out;
    logic                      ctrl_out, res_valid_out, busy_out, done_out;

    systolic_vec_feeder #(.WIDTH(WIDTH), .ROW(ROW), .ARR_LAT(ARR_LAT), .CNT_W(CNT_W)) dut (
        .clk_in1(clk_in1), .nrst_in1(nrst_in1), .start_in(start_in), .num_vec_in(num_vec_in),
        .w_valid_in(w_valid_in), .w_data_in(w_data_in), .w_ready_out(w_ready_out),
        .f_valid_in(f_valid_in), .f_data_in(f_data_in), .f_ready_out(f_ready_out),
        .ctrl_out(ctrl_out), .weight_out(weight_out), .feature_out(feature_out),
        .res_valid_out(res_valid_out), .busy_out(busy_out), .done_out(done_out)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    // Expected outputs per cycle, scheduled from accepted transactions.
    bit                      exp_ctrl [MAXC];
    bit [WIDTH-1:0]          exp_w    [MAXC];
    bit [ROW-1:0][WIDTH-1:0] exp_f    [MAXC];
    bit                      exp_rv   [MAXC];
    bit                      exp_done [MAXC];

    // Job-level model: weights/vectors accepted so far and the done cycle.
    bit             job;
    int             n_w, n_f, n_tot, done_at;
    bit [WIDTH-1:0] cur_w;
    int             cyc, n_checks, n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic tick(input bit rst_n, input bit st, input logic [CNT_W-1:0] nv,
                        input bit wv, input logic [WIDTH-1:0] wd,
                        input bit fv, input logic [ROW-1:0][WIDTH-1:0] fd);
        bit rdy_w, rdy_f, xw, xf, job_before;
        @(posedge clk_in1);
        #1;
        cyc++;
        if (cyc > MAXC - 16) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d exp=<%0d", cyc, cyc, MAXC - 16);
            $fatal(1, "cycle budget exhausted");
        end
        rdy_w = job && (n_w < ROW);
        rdy_f = job && (n_w == ROW) && (n_f < n_tot);
        check("ctrl_out",      ctrl_out,      exp_ctrl[cyc]);
        check("weight_out",    weight_out,    exp_w[cyc]);
        check("feature_out",   feature_out,   exp_f[cyc]);
        check("res_valid_out", res_valid_out, exp_rv[cyc]);
        check("done_out",      done_out,      exp_done[cyc]);
        check("busy_out",      busy_out,      job);
        check("w_ready_out",   w_ready_out,   rdy_w);
        check("f_ready_out",   f_ready_out,   rdy_f);

        nrst_in1 = rst_n; start_in = st; num_vec_in = nv;
        w_valid_in = wv; w_data_in = wd; f_valid_in = fv; f_data_in = fd;

        if (!rst_n) begin
            for (int m = cyc + 1; m < MAXC; m++) begin
                exp_ctrl[m] = 0; exp_w[m] = '0; exp_f[m] = '0; exp_rv[m] = 0; exp_done[m] = 0;
            end
            job = 0; cur_w = '0; done_at = -1; n_w = 0; n_f = 0; n_tot = 0;
            return;
        end
        job_before = job;
        xw = wv && rdy_w;
        xf = fv && rdy_f;
        if (xw) begin
            cur_w = wd;
            n_w++;
        end
        exp_ctrl[cyc+1] = xw;
        exp_w[cyc+1]    = cur_w;
        if (xf) begin
            for (int i = 0; i < ROW; i++)
                exp_f[cyc+1+SKEW*i][i] = fd[i];
            exp_rv[cyc+1+D] = 1;
            n_f++;
            if (n_f == n_tot) begin
                done_at = cyc + 2 + D;
                exp_done[done_at] = 1;
            end
        end
        if (job_before && done_at == cyc) job = 0;
        if (st && !job_before) begin
            if (nv == '0) exp_done[cyc+1] = 1;
            else begin
                job = 1; n_w = 0; n_f = 0; n_tot = int'(nv); done_at = -1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            tick(1, 0, '0, 0, WIDTH'($urandom), 0, (ROW*WIDTH)'($urandom));
    endtask

    task automatic wgt(input logic [WIDTH-1:0] v);
        tick(1, 0, '0, 1, v, 0, '0);
    endtask

    task automatic feat(input logic [ROW-1:0][WIDTH-1:0] v);
        tick(1, 0, '0, 0, '0, 1, v);
    endtask

    initial begin
        job = 0; n_w = 0; n_f = 0; n_tot = 0; done_at = -1; cur_w = '0;
        cyc = 0; n_checks = 0; n_pass = 0;
        nrst_in1 = 0; start_in = 1; num_vec_in = 8'd3;
        w_valid_in = 1; w_data_in = 8'h5a; f_valid_in = 1; f_data_in = 16'hbeef;

        // Reset with random inputs on both cycles.
        tick(0, 1'($urandom), CNT_W'($urandom), 1'($urandom), WIDTH'($urandom),
             1'($urandom), (ROW*WIDTH)'($urandom));
        tick(1, 0, '0, 0, '0, 0, '0);
        idle(2);

        // Two vectors, back-to-back weights 1,4 then features {1,0},{1,5}.
        tick(1, 1, 8'd2, 0, '0, 0, '0);
        wgt(8'd1); wgt(8'd4);
        feat({8'd0, 8'd1}); feat({8'd5, 8'd1});
        idle(8);

        // Weight gap: ctrl_out drops, weight_out holds.
        tick(1, 1, 8'd1, 0, '0, 0, '0);
        wgt(8'd1);
        tick(1, 0, '0, 0, 8'hee, 0, 16'h1234);
        tick(1, 0, '0, 0, 8'hdd, 1, 16'h5678);
        tick(1, 0, '0, 0, 8'hcc, 0, '0);
        wgt(8'd4);
        feat({8'd5, 8'd1});
        idle(8);

        // Zero-length job, then start pulses ignored while busy.
        tick(1, 1, 8'd0, 1, 8'h11, 1, 16'h2222);
        idle(3);
        tick(1, 1, 8'd1, 0, '0, 0, '0);
        tick(1, 1, 8'd7, 1, 8'h21, 0, '0);
        tick(1, 1, 8'd7, 1, 8'h22, 0, '0);
        tick(1, 1, 8'd0, 0, '0, 1, 16'h3344);
        idle(8);

        // Reset after 1 of 3 vectors, then a normal job.
        tick(1, 1, 8'd3, 0, '0, 0, '0);
        wgt(8'd9); wgt(8'd8);
        feat({8'd7, 8'd6});
        tick(0, 0, '0, 1, 8'h77, 1, 16'h7777);
        tick(1, 0, '0, 0, '0, 0, '0);
        idle(6);
        tick(1, 1, 8'd3, 0, '0, 0, '0);
        wgt(8'd2); wgt(8'd3);
        feat({8'd1, 8'd2}); feat({8'd3, 8'd4}); feat({8'd5, 8'd6});
        idle(8);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 2500; k++) begin
            tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0),
                 CNT_W'($urandom_range(0, 4)),
                 ($urandom_range(0, 9) < 7), WIDTH'($urandom),
                 ($urandom_range(0, 9) < 7), (ROW*WIDTH)'($urandom));
        end

        // Finish any open job with full-rate streams, bounded.
        for (int k = 0; k < 300 && job; k++)
            tick(1, 0, '0, 1, WIDTH'($urandom), 1, (ROW*WIDTH)'($urandom));
        check("drain_timeout", job, 0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/systolic_vec_feeder.md
SYSTOLIC_VEC_FEEDER -- requirements
Module: systolic_vec_feeder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter WIDTH, default 8: bits per weight and feature element.
REQ-003 Parameter ROW, default 2: PEs in the driven systolic vector (ROW >= 1).
REQ-004 Parameter ARR_LAT, default 2: cycles from feature presented to vector result valid.
REQ-005 Parameter CNT_W, default 8: width of the vector-count field.
REQ-006 clk_in1  input  1  rising-edge clock.
REQ-007 nrst_in1  input  1  synchronous active-low reset.
REQ-008 start_in  input  1  one-cycle job start pulse.
REQ-009 num_vec_in  input  CNT_W  feature vectors in the job, sampled with start_in.
REQ-010 w_valid_in / w_data_in / w_ready_out  in/in/out  1/WIDTH/1  weight stream handshake.
REQ-011 f_valid_in / f_data_in[ROW] / f_ready_out  in/in/out  1/WIDTHxROW/1  feature vector handshake.
REQ-012 ctrl_out  output  1  array mode: 1 = shift weight in, 0 = compute.
REQ-013 weight_out  output  WIDTH  weight to array weight input.
REQ-014 feature_out[ROW]  output  WIDTHxROW  per-row feature inputs to array.
REQ-015 res_valid_out  output  1  array vec_out is a valid result this cycle.
REQ-016 busy_out / done_out  output  1/1  job active / one-cycle job completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_W, FEED, DRAIN; transfer = valid & ready in the same cycle.
REQ-018 IDLE: start_in with num_vec_in != 0 -> LOAD_W, latch count; num_vec_in == 0 -> done_out high next cycle, stay IDLE.
REQ-019 start_in outside IDLE SHALL be ignored.
REQ-020 LOAD_W: w_ready_out = 1; f_ready_out = 0; after ROW weight transfers -> FEED.
REQ-021 Each weight transfer SHALL drive ctrl_out = 1 and weight_out = w_data_in on the next cycle (registered, 1-cycle latency).
REQ-022 Cycles without a weight transfer SHALL drive ctrl_out = 0 and hold weight_out; feature_out = 0 throughout LOAD_W.
REQ-023 FEED: f_ready_out = 1, w_ready_out = 0, ctrl_out = 0; each transfer drives feature_out = f_data_in on the next cycle.
REQ-024 FEED cycles without a transfer SHALL drive feature_out = 0 (bubble, no result generated).
REQ-025 After num_vec_in feature transfers -> DRAIN; count wraps never (CNT_W-bit down-counter stops at 0).
REQ-026 res_valid_out SHALL assert exactly D cycles after each non-bubble feature_out cycle, via a D-deep valid shift register; D = ARR_LAT (skew off).
REQ-027 DRAIN: feature_out = 0, both readies 0; when the valid shift register is empty -> IDLE with done_out high for one cycle.
REQ-028 busy_out SHALL be 1 in LOAD_W, FEED, DRAIN; 0 in IDLE.
REQ-029 Back-to-back transfers every cycle SHALL be sustained with no inserted bubbles.

Reset
REQ-030 While nrst_in1 = 0 at a clock edge: state IDLE, ctrl_out, weight_out, feature_out, res_valid_out, busy_out, done_out, both readies = 0, counters and valid pipeline cleared.
REQ-031 Reset mid-job SHALL abort the job; no done_out is generated for it.

Configuration
REQ-032 Macro SYS_FEED_SKEW_EN defined: feature_out[i] SHALL be delayed i extra cycles (row 0 undelayed) and D = ARR_LAT + ROW - 1.
REQ-033 SYS_FEED_SKEW_EN undefined: all rows of a vector SHALL appear in the same cycle; skew registers absent; D = ARR_LAT.
REQ-034 Skew registers SHALL reset to 0 and DRAIN SHALL wait until skew pipeline empties.

Verification (ROW=2, WIDTH=8, ARR_LAT=2, skew off unless noted)
REQ-035 nrst_in1 low 2 cycles with random inputs -> every output 0, both readies 0.
REQ-036 start, num_vec=2, weights 1,4 back-to-back, then features {1,0},{1,5} back-to-back -> ctrl_out 1 for 2 cycles with weight_out 1 then 4; feature_out {1,0},{1,5} next; res_valid_out 2 cycles later for 2 cycles; done_out 1 cycle after.
REQ-037 Weight 1, 3-cycle w_valid gap, weight 4 -> ctrl_out 0 during gap, weight_out held at 1, feature_out 0.
REQ-038 SYS_FEED_SKEW_EN, feature {1,5} transferred at T -> feature_out[0]=1 at T+1, feature_out[1]=5 at T+2, res_valid_out at T+1+3.
REQ-039 start with num_vec=0 -> done_out next cycle, ctrl_out and w_ready_out never asserted.
REQ-040 nrst_in1 low in FEED after 1 of 3 vectors -> all outputs 0 next cycle, no done_out; new start runs normally.
